// File: rtl/lbp_hist_pkg.sv
// lbp_pkg: shared frame/bin constants, FSM state type, uniform-LBP rank mapping (bin mode set by LBP_HIST_UNIFORM_EN)
package lbp_pkg;
  localparam int IMG_W = 128;
  localparam int FRAME_PIXELS = 15876;
  localparam int COUNT_W = 14;
`ifdef LBP_HIST_UNIFORM_EN
  localparam int NUM_BINS = 59;
`else
  localparam int NUM_BINS = 256;
`endif
  localparam int BIN_IDX_W = $clog2(NUM_BINS);
  typedef enum logic [1:0] {ACCUM, DUMP, CLEAR} state_t;
  function automatic logic is_uniform(input logic [7:0] c);
    logic [7:0] t = c ^ {c[0], c[7:1]};
    return $countones(t) <= 2;
  endfunction
  function automatic logic [7:0] uniform_rank(input logic [7:0] c);
    logic [7:0] r = '0;
    if (!is_uniform(c)) return 8'd58;
    for (int i = 0; i < 256; i++) if (i < int'(c) && is_uniform(8'(i))) r++;
    return r;
  endfunction
endpackage

// File: rtl/lbp_hist_if.sv
// lbp_hist_if: lbp_valid/lbp_addr/lbp_data strobe in; hist_valid/hist_ready/hist_bin/hist_count/hist_done dump out; drop_err flag
interface lbp_hist_if;
  logic lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0] lbp_data;
  logic hist_valid, hist_ready, hist_done, drop_err;
  logic [7:0] hist_bin;
  logic [13:0] hist_count;
  modport master (output lbp_valid, lbp_addr, lbp_data, hist_ready, input hist_valid, hist_bin, hist_count, hist_done, drop_err);
  modport slave (input lbp_valid, lbp_addr, lbp_data, hist_ready, output hist_valid, hist_bin, hist_count, hist_done, drop_err);
endinterface

// File: rtl/lbp_hist_rd.sv
// lbp_hist_rd: dump sequencer; ports clk, reset, start_i, hist_ready_i -> hist_valid_o, hist_bin_o, hist_done_o, last_xfer_o
module lbp_hist_rd import lbp_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       hist_ready_i,
  output logic       hist_valid_o,
  output logic [7:0] hist_bin_o,
  output logic       hist_done_o,
  output logic       last_xfer_o
);
  logic valid_q, valid_d, done_q, done_d, xfer;
  logic [7:0] bin_q, bin_d;
  always_comb begin
    xfer = valid_q & hist_ready_i;
    last_xfer_o = xfer & (bin_q == 8'(NUM_BINS - 1));
    valid_d = start_i | (valid_q & ~last_xfer_o);
    bin_d = start_i ? '0 : (xfer & ~last_xfer_o) ? bin_q + 8'd1 : bin_q;
    done_d = last_xfer_o;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      bin_q <= '0;
      done_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bin_q <= bin_d;
      done_q <= done_d;
    end
  end
  assign hist_valid_o = valid_q;
  assign hist_bin_o = bin_q;
  assign hist_done_o = done_q;
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: LBP histogram accumulator (ACCUM/DUMP/CLEAR); ports clk, reset, bus (lbp_hist_if.slave); LBP_HIST_UNIFORM_EN selects 59 uniform bins
module lbp_hist import lbp_pkg::*; (
  input logic clk,
  input logic reset,
  lbp_hist_if.slave bus
);
  state_t state_q;
  logic [COUNT_W-1:0] bins_q [NUM_BINS];
  logic [COUNT_W-1:0] samples_q;
  logic drop_err_q, interior, full, accept, start, last_xfer;
  logic [BIN_IDX_W-1:0] idx;
  logic [6:0] row, col;
  always_comb begin
    {row, col} = bus.lbp_addr;
    interior = row != '0 && row != 7'(IMG_W - 1) && col != '0 && col != 7'(IMG_W - 1);
    full = samples_q == COUNT_W'(FRAME_PIXELS);
    // a full frame waits one cycle before DUMP; strobes in that gap are dropped so the frame stays exact
    accept = bus.lbp_valid && state_q == ACCUM && interior && !full;
    start = state_q == ACCUM && full;
`ifdef LBP_HIST_UNIFORM_EN
    idx = BIN_IDX_W'(uniform_rank(bus.lbp_data));
`else
    idx = bus.lbp_data;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      samples_q <= '0;
      drop_err_q <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
    end else begin
      if (bus.lbp_valid && !accept) drop_err_q <= 1'b1;
      if (state_q == CLEAR) begin
        for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
        samples_q <= '0;
      end else if (accept) begin
        bins_q[idx] <= (&bins_q[idx]) ? bins_q[idx] : bins_q[idx] + COUNT_W'(1);
        samples_q <= samples_q + COUNT_W'(1);
      end
      state_q <= state_q == CLEAR ? ACCUM : start ? DUMP : last_xfer ? CLEAR : state_q;
    end
  end
  lbp_hist_rd u_rd (
    .clk(clk),
    .reset(reset),
    .start_i(start),
    .hist_ready_i(bus.hist_ready),
    .hist_valid_o(bus.hist_valid),
    .hist_bin_o(bus.hist_bin),
    .hist_done_o(bus.hist_done),
    .last_xfer_o(last_xfer)
  );
  assign bus.hist_count = bins_q[bus.hist_bin[BIN_IDX_W-1:0]];
  assign bus.drop_err = drop_err_q;
endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 lbp_valid  input  1  single-cycle strobe; lbp_addr/lbp_data are valid this cycle.
REQ-004 lbp_addr  input  14  pixel address, {row[13:7], col[6:0]}.
REQ-005 lbp_data  input  8  LBP code of that pixel.
REQ-006 hist_valid  output  1  hist_bin/hist_count are presented.
REQ-007 hist_ready  input  1  consumer accepts the presented bin.
REQ-008 hist_bin  output  8  bin index being presented.
REQ-009 hist_count  output  14  occupancy of hist_bin.
REQ-010 hist_done  output  1  one-cycle pulse after the last bin is accepted.
REQ-011 drop_err  output  1  sticky; set when a strobe is discarded.

Function
REQ-012 States SHALL be ACCUM, DUMP, CLEAR; reset enters ACCUM.
REQ-013 In ACCUM, a strobe with row and col both in 1..126 SHALL increment bin[lbp_data] by 1 and increment the 14-bit sample counter; the update is visible the next cycle.
REQ-014 In ACCUM, a strobe with row or col equal to 0 or 127 SHALL be discarded: no bin update, no counter update, drop_err set.
REQ-015 Bin increments SHALL saturate at 16383.
REQ-016 Back-to-back strobes SHALL each be counted, including repeated codes on consecutive cycles.
REQ-017 When the sample counter reaches 15876 (126*126), the state SHALL move to DUMP on the next edge, with hist_bin=0 and hist_valid=1.
REQ-018 In DUMP, a bin SHALL transfer on any cycle with hist_valid=1 and hist_ready=1.
REQ-019 In DUMP, hist_bin/hist_count SHALL hold stable while hist_valid=1 and hist_ready=0.
REQ-020 After each transfer, hist_bin SHALL advance by 1 on the next cycle.
REQ-021 The transfer of the last bin SHALL drive hist_valid=0 and pulse hist_done for exactly one cycle, then enter CLEAR.
REQ-022 Any strobe in DUMP or CLEAR SHALL be discarded and SHALL set drop_err.
REQ-023 CLEAR SHALL zero all bins and the sample counter in one cycle, then return to ACCUM; drop_err is not cleared.
REQ-024 hist_count SHALL always equal bin[hist_bin] as registered; no combinational path from lbp_* to hist_*.

Reset
REQ-025 Reset SHALL set all bins, the sample counter, hist_valid, hist_bin, hist_count, hist_done and drop_err to 0 and the state to ACCUM, taking effect immediately, including mid-DUMP.

Configuration
REQ-026 With LBP_HIST_UNIFORM_EN defined, lbp_data SHALL be mapped before binning:
  - uniform codes (at most 2 circular 0/1 transitions, 58 values), ranked ascending by code value, map to bins 0..57;
  - all other codes map to bin 58;
  - DUMP presents bins 0..58 only.
REQ-027 Without LBP_HIST_UNIFORM_EN, lbp_data SHALL be used directly and DUMP presents bins 0..255.

Structure
REQ-028 The shared package lbp_pkg SHALL hold IMG_W=128, FRAME_PIXELS=15876, NUM_BINS (256 or 59), COUNT_W=14 and the uniform-rank mapping function.
REQ-029 The dump sequencer SHALL be one sub-module, lbp_hist_rd, owning hist_valid/hist_bin/hist_done and the ready handshake.

Verification
REQ-030 Scenario: 15876 interior strobes, all lbp_data=0x00, hist_ready=1 -> dump shows bin0=15876 and all other bins 0; hist_done pulses once, 256 cycles after the first hist_valid.
REQ-031 Scenario: 15876 strobes, codes cycling 0..255 back-to-back -> bins 0..3=63, bins 4..255=62.
REQ-032 Scenario: strobe at addr 0x0000 and at row 5/col 127 -> both dropped, drop_err=1, sample counter unchanged.
REQ-033 Scenario: during dump, hist_ready low for 5 cycles at bin 7 -> bin 7 held for 5 cycles; no bin is skipped or repeated.
REQ-034 Scenario: reset asserted mid-DUMP at bin 100 -> all outputs 0 and state ACCUM; a new full frame dumps correctly.
REQ-035 Scenario (LBP_HIST_UNIFORM_EN defined): codes 0x00, 0x01, 0x05 -> bin0 and bin1 each +1, bin58 +1; 59 bins dumped.
